// File: rtl/dmem_responder.sv
// Data-memory responder: serves CPU loads/stores from an internal word array with fixed latency.
// Optional DMEM_RANGE_CHECK_EN flags and suppresses accesses outside the mapped window.
module dmem_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        d_mem_read,
  input  logic        d_mem_write,
  input  logic [31:0] d_mem_address,
  input  logic [31:0] d_mem_wdata,
  input  logic [3:0]  mem_byte_en,
  output logic [31:0] d_mem_rdata,
  output logic        d_mem_resp,
  output logic        d_mem_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            lat_we_q, lat_we_d;
  logic            lat_oor_q, lat_oor_d;
  logic            lat_err_q, lat_err_d;
  logic [AW-1:0]   lat_idx_q, lat_idx_d;
  logic [31:0]     lat_wdata_q, lat_wdata_d;
  logic [3:0]      lat_be_q, lat_be_d;
  logic [31:0]     rdata_d;
  logic            resp_d, err_d;

  logic [31:0]     mem [DEPTH];

  logic [AW-1:0]   acc_idx_c;
  logic            acc_oor_c;
  logic            acc_err_c;

  assign acc_idx_c = AW'((d_mem_address - BASE_ADDR) >> 2);

`ifdef DMEM_RANGE_CHECK_EN
  // Addresses below BASE_ADDR wrap to large offsets, so one unsigned compare covers both ends.
  assign acc_oor_c = (33'(d_mem_address - BASE_ADDR) >= (33'(DEPTH) << 2));
`else
  assign acc_oor_c = 1'b0;
`endif

  assign acc_err_c = (d_mem_read & d_mem_write) | acc_oor_c;

  // Next-state, request latch and registered-output values
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    lat_we_d    = lat_we_q;
    lat_oor_d   = lat_oor_q;
    lat_err_d   = lat_err_q;
    lat_idx_d   = lat_idx_q;
    lat_wdata_d = lat_wdata_q;
    lat_be_d    = lat_be_q;
    rdata_d     = d_mem_rdata;
    resp_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: begin
        if (d_mem_read | d_mem_write) begin
          lat_we_d    = d_mem_write;
          lat_oor_d   = acc_oor_c;
          lat_err_d   = acc_err_c;
          lat_idx_d   = acc_idx_c;
          lat_wdata_d = d_mem_wdata;
          lat_be_d    = mem_byte_en;
          cnt_d       = CW'(LATENCY - 1);
          if (LATENCY == 1) begin
            state_d = RESP;
            resp_d  = 1'b1;
            err_d   = acc_err_c;
            if (!d_mem_write) rdata_d = acc_oor_c ? 32'h0 : mem[acc_idx_c];
          end else begin
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = RESP;
          resp_d  = 1'b1;
          err_d   = lat_err_q;
          if (!lat_we_q) rdata_d = lat_oor_q ? 32'h0 : mem[lat_idx_q];
        end
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lat_we_q    <= 1'b0;
      lat_oor_q   <= 1'b0;
      lat_err_q   <= 1'b0;
      lat_idx_q   <= '0;
      lat_wdata_q <= '0;
      lat_be_q    <= '0;
      d_mem_rdata <= '0;
      d_mem_resp  <= 1'b0;
      d_mem_err   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lat_we_q    <= lat_we_d;
      lat_oor_q   <= lat_oor_d;
      lat_err_q   <= lat_err_d;
      lat_idx_q   <= lat_idx_d;
      lat_wdata_q <= lat_wdata_d;
      lat_be_q    <= lat_be_d;
      d_mem_rdata <= rdata_d;
      d_mem_resp  <= resp_d;
      d_mem_err   <= err_d;
    end
  end

  // Store commits on the edge leaving RESP; the array itself is never reset
  always_ff @(posedge clk) begin
    if (state_q == RESP && lat_we_q && !lat_oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be_q[i]) mem[lat_idx_q][8*i +: 8] <= lat_wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (DEPTH=1024, LATENCY=2, BASE_ADDR=0).
module tb_dmem_responder;

  logic        clk;
  logic        rst;
  logic        d_mem_read;
  logic        d_mem_write;
  logic [31:0] d_mem_address;
  logic [31:0] d_mem_wdata;
  logic [3:0]  mem_byte_en;
  logic [31:0] d_mem_rdata;
  logic        d_mem_resp;
  logic        d_mem_err;

  int checks = 0;
  int errors = 0;

  dmem_responder #(.DEPTH(1024), .LATENCY(2), .BASE_ADDR(32'h0)) dut (
    .clk          (clk),
    .rst          (rst),
    .d_mem_read   (d_mem_read),
    .d_mem_write  (d_mem_write),
    .d_mem_address(d_mem_address),
    .d_mem_wdata  (d_mem_wdata),
    .mem_byte_en  (mem_byte_en),
    .d_mem_rdata  (d_mem_rdata),
    .d_mem_resp   (d_mem_resp),
    .d_mem_err    (d_mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one request at a negedge, hold it until resp (bounded), then drop it.
  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [3:0] be,
                        output int lat, output logic [31:0] rdata, output logic err,
                        output logic resp_after);
    d_mem_read    = rd;
    d_mem_write   = wr;
    d_mem_address = addr;
    d_mem_wdata   = wd;
    mem_byte_en   = be;
    lat   = 0;
    rdata = 32'hx;
    err   = 1'bx;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (d_mem_resp) begin
        lat   = k;
        rdata = d_mem_rdata;
        err   = d_mem_err;
      end
    end
    d_mem_read  = 1'b0;
    d_mem_write = 1'b0;
    @(negedge clk);
    resp_after = d_mem_resp;
  endtask

  int          lat;
  logic [31:0] rd;
  logic        er;
  logic        ra;
  logic        seen;
  logic [9:0]  pulses;

  initial begin
    rst = 1'b0;
    d_mem_read = 1'b0;
    d_mem_write = 1'b0;
    d_mem_address = 32'h0;
    d_mem_wdata = 32'h0;
    mem_byte_en = 4'h0;
    @(negedge clk);
    @(negedge clk);
    check("reset_resp", 32'(d_mem_resp), 32'h0);
    check("reset_rdata", d_mem_rdata, 32'h0);
    check("reset_err", 32'(d_mem_err), 32'h0);
    rst = 1'b1;
    @(negedge clk);

    // Preload word 5, then reset in the middle of a second store to it
    access(1'b0, 1'b1, 32'h14, 32'h1234_5678, 4'hF, lat, rd, er, ra);
    check("preload_lat", 32'(lat), 32'd2);
    d_mem_write   = 1'b1;
    d_mem_address = 32'h14;
    d_mem_wdata   = 32'hCAFE_F00D;
    mem_byte_en   = 4'hF;
    @(negedge clk);
    rst = 1'b0;
    d_mem_write = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen = seen | d_mem_resp;
    end
    check("rst_mid_no_resp", 32'(seen), 32'h0);
    check("rst_mid_rdata", d_mem_rdata, 32'h0);
    check("rst_mid_err", 32'(d_mem_err), 32'h0);
    rst = 1'b1;
    @(negedge clk);
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, rd, er, ra);
    check("rst_mid_old_word", rd, 32'h1234_5678);

    // Full-word store and load with latency checks
    access(1'b0, 1'b1, 32'h14, 32'hDEAD_BEEF, 4'hF, lat, rd, er, ra);
    check("wr_lat", 32'(lat), 32'd2);
    check("wr_err", 32'(er), 32'h0);
    check("wr_resp_one_cycle", 32'(ra), 32'h0);
    check("wr_keeps_rdata", d_mem_rdata, 32'h1234_5678);
    access(1'b1, 1'b0, 32'h14, 32'h0, 4'h0, lat, rd, er, ra);
    check("rd_lat", 32'(lat), 32'd2);
    check("rd_data", rd, 32'hDEAD_BEEF);
    check("rd_err", 32'(er), 32'h0);

    // Byte lanes on word 8
    access(1'b0, 1'b1, 32'h20, 32'h1122_3344, 4'hF, lat, rd, er, ra);
    access(1'b0, 1'b1, 32'h20, 32'hAABB_CCDD, 4'b0101, lat, rd, er, ra);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, ra);
    check("be_0101", rd, 32'h11BB_33DD);
    access(1'b0, 1'b1, 32'h20, 32'hFFFF_FFFF, 4'b0000, lat, rd, er, ra);
    check("be_0000_lat", 32'(lat), 32'd2);
    access(1'b1, 1'b0, 32'h20, 32'h0, 4'h0, lat, rd, er, ra);
    check("be_0000_unchanged", rd, 32'h11BB_33DD);

    // Read held for 10 cycles: pulses two, five and eight cycles after first accept
    d_mem_read    = 1'b1;
    d_mem_address = 32'h14;
    pulses = '0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      pulses[k] = d_mem_resp;
      if (d_mem_resp) check("held_rdata", d_mem_rdata, 32'hDEAD_BEEF);
    end
    d_mem_read = 1'b0;
    check("held_pulses", 32'(pulses), 32'(10'b00_1001_0010));
    for (int k = 0; k < 3; k++) @(negedge clk);

    // Read and write together act as a flagged store
    access(1'b1, 1'b1, 32'h0, 32'h5, 4'hF, lat, rd, er, ra);
    check("conflict_lat", 32'(lat), 32'd2);
    check("conflict_err", 32'(er), 32'h1);
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er, ra);
    check("conflict_word0", rd, 32'h5);
    check("conflict_rd_err", 32'(er), 32'h0);

    // One word past the window
    access(1'b0, 1'b1, 32'h1000, 32'h77, 4'hF, lat, rd, er, ra);
    check("oor_wr_lat", 32'(lat), 32'd2);
`ifdef DMEM_RANGE_CHECK_EN
    check("oor_wr_err", 32'(er), 32'h1);
`else
    check("oor_wr_err", 32'(er), 32'h0);
`endif
    access(1'b1, 1'b0, 32'h0, 32'h0, 4'h0, lat, rd, er, ra);
`ifdef DMEM_RANGE_CHECK_EN
    check("oor_word0", rd, 32'h5);
`else
    check("oor_word0", rd, 32'h77);
`endif
    access(1'b1, 1'b0, 32'h1000, 32'h0, 4'h0, lat, rd, er, ra);
`ifdef DMEM_RANGE_CHECK_EN
    check("oor_rd_data", rd, 32'h0);
    check("oor_rd_err", 32'(er), 32'h1);
`else
    check("oor_rd_data", rd, 32'h77);
    check("oor_rd_err", 32'(er), 32'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
